// File: rtl/stride_unpooling_unit.sv
// rtl/stride_unpooling_unit.sv - 2x2 stride unpooling: argmax scatter or nearest-neighbour upsample
module stride_unpooling_unit #(
    parameter int int_bits = 20,
    parameter int POOL_W   = 8,
    parameter int POOL_H   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [int_bits-1:0] in,
    input  logic [7:0]          RAM_out_g,
    output logic                RAM_rd_en,
    output logic [7:0]          RAM_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [int_bits-1:0] out,
    output logic                out_last,
    output logic                done
);

    localparam int JW = $clog2(POOL_W);
    localparam int CW = JW + 1;
    localparam int RW = (POOL_H > 1) ? $clog2(POOL_H) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, LOAD, EMIT_TOP, EMIT_BOT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [RW-1:0]       r_row;
    logic [JW-1:0]       r_j;
    logic [CW-1:0]       r_col;
    logic [7:0]          r_grp;
    logic                r_mode;
    logic                r_done;
    logic [1:0]          r_idx [POOL_W];
    logic [int_bits-1:0] r_val [POOL_W];

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_col_end;
    logic                w_row_end;
    logic                w_grp_end;
    logic                w_j_end;
    logic [JW-1:0]       w_src;
    logic [1:0]          w_sel_idx;
    logic [int_bits-1:0] w_sel_val;
    logic                w_hit;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign w_col_end  = (r_col == CW'(2 * POOL_W - 1));
    assign w_row_end  = (r_row == RW'(POOL_H - 1));
    assign w_grp_end  = (r_j[1:0] == 2'b11);
    assign w_j_end    = (r_j == JW'(POOL_W - 1));
    assign w_src      = r_col[CW-1:1];
    assign w_sel_idx  = r_idx[w_src];
    assign w_sel_val  = r_val[w_src];
    // Top row keeps argmax positions 0/1, bottom row 2/3; column parity picks left/right.
    assign w_hit      = r_mode | (w_sel_idx == {r_state == EMIT_BOT, r_col[0]});
    assign done       = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (start) w_next = FETCH;
            FETCH:    w_next = WAIT;
            WAIT:     w_next = LOAD;
            LOAD:     if (w_in_xfer && w_grp_end) w_next = w_j_end ? EMIT_TOP : FETCH;
            EMIT_TOP: if (w_out_xfer && w_col_end) w_next = EMIT_BOT;
            EMIT_BOT: if (w_out_xfer && w_col_end) w_next = w_row_end ? IDLE : FETCH;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        RAM_rd_en = 1'b0;
        RAM_addr  = '0;
        out_valid = 1'b0;
        out       = '0;
        out_last  = 1'b0;
        case (r_state)
            FETCH: begin
                RAM_rd_en = 1'b1;
                RAM_addr  = r_grp;
            end
            LOAD: in_ready = 1'b1;
            EMIT_TOP, EMIT_BOT: begin
                out_valid = 1'b1;
                out       = w_hit ? w_sel_val : '0;
                out_last  = (r_state == EMIT_BOT) && w_row_end && w_col_end;
            end
            default: ;
        endcase
    end

    // Groups of four elements are fetched in row-major order, so the byte address is a running count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row  <= '0;
            r_j    <= '0;
            r_col  <= '0;
            r_grp  <= '0;
            r_mode <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_out_xfer & out_last;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_row  <= '0;
                        r_j    <= '0;
                        r_col  <= '0;
                        r_grp  <= '0;
                    end
                end
                FETCH: r_grp <= r_grp + 8'd1;
                LOAD: begin
                    if (w_in_xfer) r_j <= w_j_end ? '0 : r_j + JW'(1);
                end
                EMIT_TOP: begin
                    if (w_out_xfer) r_col <= w_col_end ? '0 : r_col + CW'(1);
                end
                EMIT_BOT: begin
                    if (w_out_xfer) begin
                        if (w_col_end) begin
                            r_col <= '0;
                            r_row <= w_row_end ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == WAIT) begin
            for (int k = 0; k < 4; k++) begin
                r_idx[r_j + JW'(k)] <= RAM_out_g[2*k +: 2];
            end
        end
        if (w_in_xfer) begin
            r_val[r_j] <= in;
        end
    end

endmodule

// File: doc/stride_unpooling_unit.md
STRIDE_UNPOOLING_UNIT -- requirements
Module: stride_unpooling_unit

Interface
REQ-001 Parameter int_bits, default 20, width of signed pooled/unpooled data words.
REQ-002 Parameter POOL_W, default 8, pooled row width in elements; SHALL be a multiple of 4 and at most 64.
REQ-003 Parameter POOL_H, default 8, pooled rows per frame, at least 1.
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
REQ-007 Port mode  in  1  0 = max-unpool (zero fill); 1 = nearest upsample (replicate); sampled at start, held for the frame.
REQ-008 Ports in_valid (in, 1), in_ready (out, 1), in (in, int_bits): pooled-value stream, row-major; transfer on in_valid & in_ready.
REQ-009 Port RAM_out_g  in  8  argmax byte from global RAM, four 2-bit indices, element k at bits [2k+1:2k].
REQ-010 Ports RAM_rd_en (out, 1), RAM_addr (out, 8): argmax byte read request; data valid one cycle after RAM_rd_en.
REQ-011 Ports out_valid (out, 1), out_ready (in, 1), out (out, int_bits): unpooled stream, row-major over 2*POOL_H rows of 2*POOL_W.
REQ-012 Ports out_last (out, 1) high with the final output word of the frame; done (out, 1) one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, WAIT, LOAD, EMIT_TOP, EMIT_BOT.
REQ-014 IDLE -> FETCH on start; start in any other state is ignored.
REQ-015 FETCH: RAM_rd_en=1 for exactly one cycle, RAM_addr = (r*POOL_W + j)>>2 mod 256 (r = pooled row, j = element in row); -> WAIT.
REQ-016 WAIT: register RAM_out_g into index buffer slots j..j+3; -> LOAD.
REQ-017 LOAD: in_ready=1; each transfer writes in to value buffer slot j, j increments; after the 4th transfer of the group, -> FETCH if j<POOL_W, else j=0 and -> EMIT_TOP.
REQ-018 in_ready SHALL be 0 in every state except LOAD; in_valid outside LOAD has no effect.
REQ-019 EMIT_TOP/EMIT_BOT: out_valid=1; output column c from 0 to 2*POOL_W-1, source element c>>1, parity p=c&1.
REQ-020 EMIT_TOP word = value[c>>1] if mode=1 or idx[c>>1]==p, else 0; EMIT_BOT uses idx[c>>1]==2+p.
REQ-021 c advances only on out_valid & out_ready; with out_ready=0, out and out_valid SHALL hold stable.
REQ-022 After column 2*POOL_W-1 transfers: EMIT_TOP -> EMIT_BOT (c=0); EMIT_BOT -> FETCH with r+1 if r<POOL_H-1, else IDLE.
REQ-023 out_last=1 only on EMIT_BOT, r=POOL_H-1, c=2*POOL_W-1; done=1 the cycle after that word transfers.
REQ-024 Data SHALL pass bit-exact (no sign change, no saturation); zero fill is literal 0.
REQ-025 First out_valid SHALL assert the cycle after the last LOAD transfer of a row.
REQ-026 Index/value buffers may be overwritten only in WAIT/LOAD; EMIT states never accept input.

Reset
REQ-027 reset low SHALL immediately force IDLE, r=j=c=0, and in_ready, RAM_rd_en, out_valid, out_last, done = 0, RAM_addr = 0, out = 0.
REQ-028 reset asserted mid-frame abandons the frame; no done pulse; the next start begins a fresh frame from r=0.

Verification (POOL_W=4, POOL_H=1 unless noted)
REQ-029 mode=0, RAM_out_g=0xE4, in=5,6,7,8 -> top 5,0,0,6,0,0,0,0; bottom 0,0,0,0,7,0,0,8; out_last on final 8; done next cycle.
REQ-030 mode=1, same stimulus -> both rows 5,5,6,6,7,7,8,8.
REQ-031 Random out_ready toggling plus in_valid gaps -> identical sequence to REQ-029; out stable whenever out_valid & !out_ready.
REQ-032 POOL_W=8, POOL_H=2 -> RAM_rd_en pulses with RAM_addr 0,1,2,3 in order, 64 outputs, single done.
REQ-033 in=20'hFFFFF with matching index -> output 20'hFFFFF unchanged; start pulsed during EMIT_TOP -> ignored.
REQ-034 reset low during EMIT_TOP -> all outputs 0 in the same cycle, state IDLE, no done; new start completes normally.
